// File: rtl/execute_stage_if.sv
// -----------------------------------------------------------------------------
// execute_stage_if
//   Bundles the ID/EX -> EX and EX -> EX/MEM signals of the execute stage.
//   slave  : used by execute_stage (consumes ID/EX fields and hazard/interrupt
//            controls, drives the registered EX/MEM fields, flags, interrupt
//            counter and intBusy).
//   master : used by the upstream pipeline / testbench (the mirror image).
// Parameters
//   DATA_W      datapath width
//   REG_ADDR_W  register-file address width
//   ALU_OP_W    ALU opcode width
// -----------------------------------------------------------------------------
interface execute_stage_if #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 3,
  parameter int ALU_OP_W   = 4
);
  // ID/EX side
  logic [ALU_OP_W-1:0]   aluOp;
  logic [DATA_W-1:0]     Rsrc_value;
  logic [DATA_W-1:0]     Rdst_value;
  logic [DATA_W-1:0]     imm;
  logic                  useImm;
  logic [3:0]            shamt;
  logic [REG_ADDR_W-1:0] Rdst_address;
  logic                  memRead;
  logic                  memWrite;
  logic                  WB;
  logic                  push;
  logic                  pop;
  logic [1:0]            shmnt_mem_in;
  logic                  setFlags;
  logic                  stall;
  logic                  flush;
  logic                  intReq;

  // EX/MEM side
  logic [DATA_W-1:0]     EXMEM_ALU_result;
  logic [DATA_W-1:0]     EXMEM_Rsrc_value;
  logic [DATA_W-1:0]     EXMEM_Rdst_value;
  logic [REG_ADDR_W-1:0] EXMEM_Rdst_address;
  logic                  EXMEM_memRead;
  logic                  EXMEM_memWrite;
  logic                  EXMEM_WB;
  logic                  EXMEM_push;
  logic                  EXMEM_pop;
  logic [1:0]            EXMEM_shmnt_mem;
  logic [2:0]            flagReg;
  logic [1:0]            intCounterValue;
  logic                  intSignalFromCounter;
  logic                  intBusy;

  modport slave (
    input  aluOp, Rsrc_value, Rdst_value, imm, useImm, shamt, Rdst_address,
           memRead, memWrite, WB, push, pop, shmnt_mem_in, setFlags, stall,
           flush, intReq,
    output EXMEM_ALU_result, EXMEM_Rsrc_value, EXMEM_Rdst_value,
           EXMEM_Rdst_address, EXMEM_memRead, EXMEM_memWrite, EXMEM_WB,
           EXMEM_push, EXMEM_pop, EXMEM_shmnt_mem, flagReg, intCounterValue,
           intSignalFromCounter, intBusy
  );

  modport master (
    output aluOp, Rsrc_value, Rdst_value, imm, useImm, shamt, Rdst_address,
           memRead, memWrite, WB, push, pop, shmnt_mem_in, setFlags, stall,
           flush, intReq,
    input  EXMEM_ALU_result, EXMEM_Rsrc_value, EXMEM_Rdst_value,
           EXMEM_Rdst_address, EXMEM_memRead, EXMEM_memWrite, EXMEM_WB,
           EXMEM_push, EXMEM_pop, EXMEM_shmnt_mem, flagReg, intCounterValue,
           intSignalFromCounter, intBusy
  );
endinterface

// File: rtl/execute_stage.sv
// -----------------------------------------------------------------------------
// execute_stage
//   Execute stage plus EX/MEM pipeline register. Computes the ALU result, owns
//   the 3-bit flag register ([0]=Z, [1]=N, [2]=C), registers the control bits
//   consumed by the memory stage and sequences interrupt context pushes.
// Ports
//   clk   : single clock, rising edge
//   rst   : asynchronous, active-high reset
//   bus   : execute_stage_if.slave -- ID/EX operands and controls, stall/flush,
//           intReq in; EXMEM_* registered fields, flagReg, intCounterValue,
//           intSignalFromCounter (registered) and intBusy (combinational) out.
// Configuration
//   INT_SAVE_FLAGS_EN defined   : interrupt pushes PC high, PC low, flags
//                                 (counter 01, 10, 11).
//   INT_SAVE_FLAGS_EN undefined : interrupt pushes PC high, PC low only.
// -----------------------------------------------------------------------------
module execute_stage #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 3,
  parameter int ALU_OP_W   = 4
) (
  input  logic          clk,
  input  logic          rst,
  execute_stage_if.slave bus
);

  localparam logic [ALU_OP_W-1:0] OP_NOP  = ALU_OP_W'(4'h0);
  localparam logic [ALU_OP_W-1:0] OP_NOT  = ALU_OP_W'(4'h1);
  localparam logic [ALU_OP_W-1:0] OP_INC  = ALU_OP_W'(4'h2);
  localparam logic [ALU_OP_W-1:0] OP_DEC  = ALU_OP_W'(4'h3);
  localparam logic [ALU_OP_W-1:0] OP_ADD  = ALU_OP_W'(4'h4);
  localparam logic [ALU_OP_W-1:0] OP_SUB  = ALU_OP_W'(4'h5);
  localparam logic [ALU_OP_W-1:0] OP_AND  = ALU_OP_W'(4'h6);
  localparam logic [ALU_OP_W-1:0] OP_OR   = ALU_OP_W'(4'h7);
  localparam logic [ALU_OP_W-1:0] OP_SHL  = ALU_OP_W'(4'h8);
  localparam logic [ALU_OP_W-1:0] OP_SHR  = ALU_OP_W'(4'h9);
  localparam logic [ALU_OP_W-1:0] OP_MOV  = ALU_OP_W'(4'hA);
  localparam logic [ALU_OP_W-1:0] OP_SETC = ALU_OP_W'(4'hB);
  localparam logic [ALU_OP_W-1:0] OP_CLRC = ALU_OP_W'(4'hC);

  // State encoding doubles as the push-slot number handed to the memory stage.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PUSH1 = 2'b01,
    PUSH2 = 2'b10,
    PUSH3 = 2'b11
  } int_state_e;

  int_state_e state_q, state_d;
  logic       cooldown_q, cooldown_d;
  logic       int_busy;
  logic       bubble;

  // ALU
  logic [DATA_W-1:0] op_a, op_b, alu_result;
  logic [DATA_W:0]   wide;
  logic              alu_c;
  logic              c_valid;

  // EX/MEM register and flags
  logic [DATA_W-1:0]     alu_result_q, alu_result_d;
  logic [DATA_W-1:0]     rsrc_value_q, rsrc_value_d;
  logic [DATA_W-1:0]     rdst_value_q, rdst_value_d;
  logic [REG_ADDR_W-1:0] rdst_address_q, rdst_address_d;
  logic                  mem_read_q, mem_read_d;
  logic                  mem_write_q, mem_write_d;
  logic                  wb_q, wb_d;
  logic                  push_q, push_d;
  logic                  pop_q, pop_d;
  logic [1:0]            shmnt_mem_q, shmnt_mem_d;
  logic [2:0]            flag_q, flag_d;
  logic [1:0]            int_counter_q, int_counter_d;
  logic                  int_signal_q, int_signal_d;

  // ---------------------------------------------------------------------------
  // ALU: 17-bit internal arithmetic so the carry/borrow falls out of bit DATA_W.
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the case/if tree can leave it unassigned and infer a latch.
  always_comb begin
    op_a       = bus.Rdst_value;
    op_b       = bus.useImm ? bus.imm : bus.Rsrc_value;
    alu_result = op_a;
    wide       = '0;
    alu_c      = 1'b0;
    c_valid    = 1'b0;
    case (bus.aluOp)
      OP_NOP: alu_result = op_a;
      OP_NOT: alu_result = ~op_a;
      OP_INC: begin
        wide       = {1'b0, op_a} + (DATA_W+1)'(1);
        alu_result = wide[DATA_W-1:0];
        alu_c      = wide[DATA_W];
        c_valid    = 1'b1;
      end
      OP_DEC: begin
        wide       = {1'b0, op_a} - (DATA_W+1)'(1);
        alu_result = wide[DATA_W-1:0];
        alu_c      = wide[DATA_W];
        c_valid    = 1'b1;
      end
      OP_ADD: begin
        wide       = {1'b0, op_a} + {1'b0, op_b};
        alu_result = wide[DATA_W-1:0];
        alu_c      = wide[DATA_W];
        c_valid    = 1'b1;
      end
      OP_SUB: begin
        // Bit DATA_W of the wide difference is the borrow.
        wide       = {1'b0, op_a} - {1'b0, op_b};
        alu_result = wide[DATA_W-1:0];
        alu_c      = wide[DATA_W];
        c_valid    = 1'b1;
      end
      OP_AND: alu_result = op_a & op_b;
      OP_OR:  alu_result = op_a | op_b;
      OP_SHL: begin
        // The last bit shifted out lands in bit DATA_W.
        wide       = {1'b0, op_a} << bus.shamt;
        alu_result = wide[DATA_W-1:0];
        alu_c      = wide[DATA_W];
        c_valid    = (bus.shamt != 4'd0);
      end
      OP_SHR: begin
        // A guard bit below the LSB catches the last bit shifted out.
        wide       = {op_a, 1'b0} >> bus.shamt;
        alu_result = wide[DATA_W:1];
        alu_c      = wide[0];
        c_valid    = (bus.shamt != 4'd0);
      end
      // MOV has no carry-out, so C is left as it was.
      OP_MOV: alu_result = op_b;
      OP_SETC: begin
        alu_c   = 1'b1;
        c_valid = 1'b1;
      end
      OP_CLRC: begin
        alu_c   = 1'b0;
        c_valid = 1'b1;
      end
      default: alu_result = op_a;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Interrupt FSM. intBusy rises combinationally in the request cycle so the
  // upstream stages hold the instruction currently in EX; that instruction is
  // replayed once the sequence ends. The first IDLE cycle after a sequence
  // ignores intReq so the held instruction is guaranteed to retire.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    int_busy = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.intReq && !bus.flush && !cooldown_q && !rst) begin
          state_d  = PUSH1;
          int_busy = 1'b1;
        end
      end
      PUSH1: begin
        state_d  = PUSH2;
        int_busy = 1'b1;
      end
      PUSH2: begin
`ifdef INT_SAVE_FLAGS_EN
        state_d  = PUSH3;
`else
        state_d  = IDLE;
`endif
        int_busy = 1'b1;
      end
      PUSH3: begin
        state_d  = IDLE;
        int_busy = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    cooldown_d = (state_q != IDLE) && (state_d == IDLE);
  end

  // ---------------------------------------------------------------------------
  // EX/MEM next values. The push slot is what the register holds while the FSM
  // is (about to be) in a PUSH state; every other busy cycle is a bubble.
  // ---------------------------------------------------------------------------
  always_comb begin
    bubble = bus.flush || bus.stall;

    alu_result_d   = alu_result;
    rsrc_value_d   = bus.Rsrc_value;
    rdst_value_d   = bus.Rdst_value;
    rdst_address_d = bus.Rdst_address;

    mem_read_d  = bus.memRead;
    mem_write_d = bus.memWrite;
    wb_d        = bus.WB;
    push_d      = bus.push;
    pop_d       = bus.pop;
    shmnt_mem_d = bus.shmnt_mem_in;

    if (state_d != IDLE) begin
      mem_read_d  = 1'b0;
      mem_write_d = 1'b1;
      wb_d        = 1'b0;
      push_d      = 1'b1;
      pop_d       = 1'b0;
      shmnt_mem_d = 2'b00;
    end else if (int_busy || bubble) begin
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      wb_d        = 1'b0;
      push_d      = 1'b0;
      pop_d       = 1'b0;
      shmnt_mem_d = 2'b00;
    end

    int_counter_d = state_d;
    int_signal_d  = (state_d != IDLE);

    flag_d = flag_q;
    if (bus.setFlags && !bubble && !int_busy) begin
      flag_d[0] = (alu_result == '0);
      flag_d[1] = alu_result[DATA_W-1];
      if (c_valid) flag_d[2] = alu_c;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      cooldown_q     <= 1'b0;
      alu_result_q   <= '0;
      rsrc_value_q   <= '0;
      rdst_value_q   <= '0;
      rdst_address_q <= '0;
      mem_read_q     <= 1'b0;
      mem_write_q    <= 1'b0;
      wb_q           <= 1'b0;
      push_q         <= 1'b0;
      pop_q          <= 1'b0;
      shmnt_mem_q    <= 2'b00;
      flag_q         <= 3'b000;
      int_counter_q  <= 2'b00;
      int_signal_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      cooldown_q     <= cooldown_d;
      alu_result_q   <= alu_result_d;
      rsrc_value_q   <= rsrc_value_d;
      rdst_value_q   <= rdst_value_d;
      rdst_address_q <= rdst_address_d;
      mem_read_q     <= mem_read_d;
      mem_write_q    <= mem_write_d;
      wb_q           <= wb_d;
      push_q         <= push_d;
      pop_q          <= pop_d;
      shmnt_mem_q    <= shmnt_mem_d;
      flag_q         <= flag_d;
      int_counter_q  <= int_counter_d;
      int_signal_q   <= int_signal_d;
    end
  end

  assign bus.EXMEM_ALU_result     = alu_result_q;
  assign bus.EXMEM_Rsrc_value     = rsrc_value_q;
  assign bus.EXMEM_Rdst_value     = rdst_value_q;
  assign bus.EXMEM_Rdst_address   = rdst_address_q;
  assign bus.EXMEM_memRead        = mem_read_q;
  assign bus.EXMEM_memWrite       = mem_write_q;
  assign bus.EXMEM_WB             = wb_q;
  assign bus.EXMEM_push           = push_q;
  assign bus.EXMEM_pop            = pop_q;
  assign bus.EXMEM_shmnt_mem      = shmnt_mem_q;
  assign bus.flagReg              = flag_q;
  assign bus.intCounterValue      = int_counter_q;
  assign bus.intSignalFromCounter = int_signal_q;
  assign bus.intBusy              = int_busy;

endmodule
